spi_master: RTL and testbench

Mode-0 SPI master that drives the SCLK/SS/MOSI/MISO link consumed by the on-board SPI_slave. It serializes one DATA_W-bit word MSB-first per transaction and captures the slave's MISO word. A local start/busy/done handshake lets test fixtures or a host-side controller inject commands toward the ALU/PWM datapath.

---
 rtl/spi_master.sv | 153 +++++++++++++++
 tb/tb_spi_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Mode-0 SPI master: one DATA_W-bit word per transaction, MSB first, with a
// start/busy/done handshake. All outputs come straight from registers.
module spi_master #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_sclk,
    output logic              o_ss,
    output logic              o_mosi,
    input  logic              i_miso
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        r_state,   w_state;
    logic [DIV_W-1:0]  r_div,     w_div;
    logic [CNT_W-1:0]  r_bit_cnt, w_bit_cnt;
    // Bits still to be sent after the one currently on MOSI.
    logic [DATA_W-2:0] r_tx_sr,   w_tx_sr;
    logic [DATA_W-1:0] r_rx_sr,   w_rx_sr;
    logic [DATA_W-1:0] r_rx_data, w_rx_data;
    logic              r_busy,    w_busy;
    logic              r_done,    w_done;
    logic              r_sclk,    w_sclk;
    logic              r_ss,      w_ss;
    logic              r_mosi,    w_mosi;
    logic              w_div_end;

    assign w_div_end = (r_div == DIV_LAST);

    always_comb begin
        w_state   = r_state;
        w_bit_cnt = r_bit_cnt;
        w_tx_sr   = r_tx_sr;
        w_rx_sr   = r_rx_sr;
        w_rx_data = r_rx_data;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_sclk    = r_sclk;
        w_ss      = r_ss;
        w_mosi    = r_mosi;
        w_div     = (r_state == S_IDLE || w_div_end) ? '0 : r_div + DIV_W'(1);

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_tx_sr   = i_tx_data[DATA_W-2:0];
                    w_mosi    = i_tx_data[DATA_W-1];
                    w_ss      = 1'b0;
                    w_busy    = 1'b1;
                    w_bit_cnt = '0;
                    w_state   = S_SETUP;
                end
            end
            S_SETUP: begin
                // Leaving SETUP is SCLK rising edge 1, so MISO is sampled here.
                if (w_div_end) begin
                    w_sclk  = 1'b1;
                    w_rx_sr = {r_rx_sr[DATA_W-2:0], i_miso};
                    w_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_div_end) begin
                    if (!r_sclk) begin
                        w_sclk  = 1'b1;
                        w_rx_sr = {r_rx_sr[DATA_W-2:0], i_miso};
                    end else begin
                        w_sclk    = 1'b0;
                        w_bit_cnt = r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state = S_HOLD;
                        end else begin
                            w_mosi  = r_tx_sr[DATA_W-2];
                            w_tx_sr = r_tx_sr << 1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (w_div_end) begin
                    w_ss    = 1'b1;
                    w_mosi  = 1'b0;
                    w_state = S_GAP;
                end
            end
            S_GAP: begin
                if (w_div_end) begin
                    w_done    = 1'b1;
                    w_busy    = 1'b0;
                    w_rx_data = r_rx_sr;
                    w_state   = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_ss      <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_div     <= w_div;
            r_bit_cnt <= w_bit_cnt;
            r_tx_sr   <= w_tx_sr;
            r_rx_sr   <= w_rx_sr;
            r_rx_data <= w_rx_data;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_sclk    <= w_sclk;
            r_ss      <= w_ss;
            r_mosi    <= w_mosi;
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rx_data = r_rx_data;
    assign o_sclk    = r_sclk;
    assign o_ss      = r_ss;
    assign o_mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (8/4, 8/1, 4/2) driven from one directed
// sequence, with a mode-0 slave model and timing derived from the protocol rules.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    // Instance 0: defaults (8, 4)
    logic       start0, busy0, done0, sclk0, ss0, mosi0, miso0;
    logic [7:0] tx0, rx0, slv0;
    int         fcnt0 = 0;
    int         done_cnt0 = 0;
    logic       q0[$];

    spi_master #(.DATA_W(8), .CLK_DIV(4)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_tx_data(tx0),
        .o_busy(busy0), .o_done(done0), .o_rx_data(rx0),
        .o_sclk(sclk0), .o_ss(ss0), .o_mosi(mosi0), .i_miso(miso0)
    );

    // Slave: presents bit 7 while selected, advances on each SCLK falling edge.
    always @(negedge sclk0 or posedge ss0) begin
        if (ss0) fcnt0 = 0;
        else if (fcnt0 < 8) fcnt0++;
    end
    assign miso0 = (fcnt0 < 8) ? slv0[3'(7 - fcnt0)] : 1'b0;
    always @(posedge sclk0) q0.push_back(mosi0);
    always @(posedge clk) if (done0 === 1'b1) done_cnt0++;

    // Instance 1: (8, 1), MISO tied high
    logic       start1, busy1, done1, sclk1, ss1, mosi1;
    logic       miso1 = 1'b1;
    logic [7:0] tx1, rx1;
    logic       q1[$];

    spi_master #(.DATA_W(8), .CLK_DIV(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_tx_data(tx1),
        .o_busy(busy1), .o_done(done1), .o_rx_data(rx1),
        .o_sclk(sclk1), .o_ss(ss1), .o_mosi(mosi1), .i_miso(miso1)
    );
    always @(posedge sclk1) q1.push_back(mosi1);

    // Instance 2: (4, 2), MISO looped back from MOSI through a delay register
    logic       start2, busy2, done2, sclk2, ss2, mosi2;
    logic       miso2 = 1'b0;
    logic [3:0] tx2, rx2;
    logic       q2[$];

    spi_master #(.DATA_W(4), .CLK_DIV(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_tx_data(tx2),
        .o_busy(busy2), .o_done(done2), .o_rx_data(rx2),
        .o_sclk(sclk2), .o_ss(ss2), .o_mosi(mosi2), .i_miso(miso2)
    );
    always @(posedge clk) miso2 <= mosi2;
    always @(posedge sclk2) q2.push_back(mosi2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One transaction on instance 0; optionally pulses start with 0xFF mid-flight.
    task automatic run0(input logic [7:0] tx, input logic [7:0] slv, input bit inject);
        int         e0;
        int         done_at;
        int         base_q;
        int         base_done;
        bit         early_drop;
        logic [7:0] rx_at;
        logic [7:0] word;
        slv0      = slv;
        tx0       = tx;
        start0    = 1'b1;
        base_q    = q0.size();
        base_done = done_cnt0;
        tick();
        e0     = cyc;
        start0 = 1'b0;
        chk("accept_ss", 32'(ss0), 32'd0);
        chk("accept_busy", 32'(busy0), 32'd1);
        chk("accept_mosi", 32'(mosi0), 32'(tx[7]));
        done_at    = -1;
        rx_at      = 8'h00;
        early_drop = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            start0 = inject && (i == 10 || i == 40);
            tx0    = (inject && i >= 10) ? 8'hFF : tx;
            tick();
            if (done0 === 1'b1) begin
                done_at = i;
                rx_at   = rx0;
                break;
            end
            if (busy0 !== 1'b1) early_drop = 1'b1;
        end
        start0 = 1'b0;
        chk("done_time", done_at, (2 * 8 + 2) * 4);
        chk("rx_data", 32'(rx_at), 32'(slv));
        chk("busy_held", 32'(early_drop), 32'd0);
        chk("busy_at_done", 32'(busy0), 32'd0);
        chk("sclk_pulses", q0.size() - base_q, 8);
        word = 8'h00;
        for (int i = 0; i < 8; i++) word = {word[6:0], q0[base_q + i]};
        chk("mosi_word", 32'(word), 32'(tx));
        repeat (3) tick();
        chk("single_done", done_cnt0 - base_done, 1);
        chk("idle_after_ss", 32'(ss0), 32'd1);
        chk("idle_after_busy", 32'(busy0), 32'd0);
    endtask

    initial begin
        int         e0;
        int         base;
        int         ss_hi;
        int         done_at;
        int         done_k[$];
        logic [7:0] rxs[$];
        logic [3:0] t4;
        logic [3:0] rx_at4;
        logic [3:0] w4;
        logic [15:0] w16;

        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        tx0    = '0;   tx1    = '0;   tx2    = '0;
        slv0   = '0;
        #23 rst_n = 1'b1;
        tick();

        chk("rst_ss", 32'(ss0), 32'd1);
        chk("rst_sclk", 32'(sclk0), 32'd0);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_rx", 32'(rx0), 32'd0);

        run0(8'hA5, 8'h3C, 1'b0);
        run0(8'hA5, 8'h3C, 1'b1);
        for (int n = 0; n < 3; n++) run0(8'($urandom), 8'($urandom), 1'b0);

        // Asynchronous reset in the middle of a transaction
        slv0   = 8'($urandom);
        tx0    = 8'h5A;
        start0 = 1'b1;
        tick();
        e0     = cyc;
        start0 = 1'b0;
        while (cyc < e0 + 29) tick();
        @(posedge clk);
        base = done_cnt0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ss", 32'(ss0), 32'd1);
        chk("arst_sclk", 32'(sclk0), 32'd0);
        chk("arst_mosi", 32'(mosi0), 32'd0);
        chk("arst_busy", 32'(busy0), 32'd0);
        chk("arst_rx", 32'(rx0), 32'd0);
        chk("arst_done", 32'(done0), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("arst_no_done", done_cnt0 - base, 0);
        run0(8'($urandom), 8'($urandom), 1'b0);

        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle_lines", 32'({sclk0, ss0, mosi0, done0}), 32'b0100);
        end

        // Back-to-back transactions with start held high, CLK_DIV=1
        base   = q1.size();
        tx1    = 8'h00;
        start1 = 1'b1;
        tick();
        e0     = cyc;
        tx1    = 8'hFF;
        chk("b2b_accept_ss", 32'(ss1), 32'd0);
        ss_hi = 0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (done1 === 1'b1) begin
                done_k.push_back(i);
                rxs.push_back(rx1);
            end
            if (i <= 19 && ss1 === 1'b1) ss_hi++;
            if (i == 19) start1 = 1'b0;
        end
        chk("b2b_done_count", done_k.size(), 2);
        chk("b2b_done0", (done_k.size() > 0) ? done_k[0] : -1, 2 * 8 + 2);
        chk("b2b_done1", (done_k.size() > 1) ? done_k[1] : -1, (2 * 8 + 2) + 1 + (2 * 8 + 2));
        chk("b2b_rx0", (rxs.size() > 0) ? 32'(rxs[0]) : 32'hDEAD, 32'hFF);
        chk("b2b_rx1", (rxs.size() > 1) ? 32'(rxs[1]) : 32'hDEAD, 32'hFF);
        chk("b2b_ss_gap", ss_hi, 1 + 1);
        chk("b2b_pulses", q1.size() - base, 16);
        w16 = 16'h0000;
        for (int i = 0; i < 16; i++) w16 = {w16[14:0], q1[base + i]};
        chk("b2b_mosi", 32'(w16), 32'h00FF);

        // DATA_W=4, CLK_DIV=2 loopback
        for (int n = 0; n < 2; n++) begin
            t4     = (n == 0) ? 4'h9 : 4'($urandom);
            base   = q2.size();
            tx2    = t4;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            done_at = -1;
            rx_at4  = 4'h0;
            for (int i = 1; i <= 60; i++) begin
                tick();
                if (done2 === 1'b1) begin
                    done_at = i;
                    rx_at4  = rx2;
                    break;
                end
            end
            chk("lb_done_time", done_at, (2 * 4 + 2) * 2);
            chk("lb_rx", 32'(rx_at4), 32'(t4));
            chk("lb_pulses", q2.size() - base, 4);
            w4 = 4'h0;
            for (int i = 0; i < 4; i++) w4 = {w4[2:0], q2[base + i]};
            chk("lb_mosi", 32'(w4), 32'(t4));
            repeat (3) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
